// File: rtl/inst_mem_loader_if.sv
// Loader/fetch bundle for inst_mem_loader: load strobe, run request, fetch request/response and status.
// master drives the load and fetch requests; slave is the instruction RAM side.
interface inst_mem_loader_if #(
   parameter int cXLEN  = 32,
   parameter int cDepth = 256
);
   localparam int cCW = $clog2(cDepth) + 1;

   logic [cXLEN-1:0] iInst2Write;
   logic             iInstWen;
   logic             iExecute;
   logic             iFetchReq;
   logic [cXLEN-1:0] iFetchAddr;
   logic [cXLEN-1:0] oFetchInst;
   logic             oFetchDv;
   logic [cCW-1:0]   oInstCount;
   logic             oLoadFull;
   logic             oRunning;
   logic             oFetchErr;

   modport master (
      output iInst2Write, iInstWen, iExecute, iFetchReq, iFetchAddr,
      input  oFetchInst, oFetchDv, oInstCount, oLoadFull, oRunning, oFetchErr
   );

   modport slave (
      input  iInst2Write, iInstWen, iExecute, iFetchReq, iFetchAddr,
      output oFetchInst, oFetchDv, oInstCount, oLoadFull, oRunning, oFetchErr
   );
endinterface

// File: rtl/inst_mem_loader.sv
// Instruction RAM loaded word-by-word in LOAD, read with 1-cycle latency in RUN; no backpressure, loads past full are dropped.
// INST_MEM_BOUNDS_CHECK_EN: fetches beyond the loaded words return NOP and raise oFetchErr.
module inst_mem_loader #(
   parameter int cXLEN  = 32,
   parameter int cDepth = 256
) (
   input  logic               iClk,
   input  logic               iRst,
   inst_mem_loader_if.slave   bus
);
   localparam int              cAW      = $clog2(cDepth);
   localparam logic [cAW:0]    cFullCnt = (cAW+1)'(cDepth);
   localparam logic [cXLEN-1:0] cNop    = cXLEN'(32'h0000_0013);

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           r_state;
   logic [cAW-1:0]   r_wr_ptr;
   logic [cAW:0]     r_count;
   logic             r_full;
   logic             r_run;
   logic             r_dv;
   logic [cXLEN-1:0] r_inst;
   logic [cXLEN-1:0] r_mem [cDepth];

   logic             w_wr_acc;
   logic [cAW:0]     w_cnt_nxt;
   logic [cAW-1:0]   w_idx;
   logic             w_fetch;
   logic             w_unused_addr;

   // Reset also blocks the write so a load strobe held through reset cannot touch memory.
   assign w_wr_acc      = (r_state == LOAD) && bus.iInstWen && !r_full && !iRst;
   assign w_cnt_nxt     = r_count + {{cAW{1'b0}}, w_wr_acc};
   assign w_idx         = bus.iFetchAddr[cAW+1:2];
   assign w_fetch       = (r_state == RUN) && bus.iFetchReq;
   assign w_unused_addr = ^{bus.iFetchAddr[cXLEN-1:cAW+2], bus.iFetchAddr[1:0]};

   always_ff @(posedge iClk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= bus.iInst2Write;
      end
   end

`ifdef INST_MEM_BOUNDS_CHECK_EN
   logic w_oob;
   logic r_err;

   assign w_oob = ({1'b0, w_idx} >= r_count);

   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_fetch && w_oob;
      end
   end

   assign bus.oFetchErr = r_err;
`else
   assign bus.oFetchErr = 1'b0;
`endif

   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_state  <= LOAD;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_run    <= 1'b0;
         r_dv     <= 1'b0;
         r_inst   <= '0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_count  <= w_cnt_nxt;
            r_full   <= (w_cnt_nxt == cFullCnt);
         end

         case (r_state)
            LOAD: begin
               // A write accepted this cycle is enough to leave LOAD.
               if (bus.iExecute && (w_cnt_nxt != '0)) begin
                  r_state <= RUN;
                  r_run   <= 1'b1;
               end
            end
            RUN: begin
               if (!bus.iExecute) begin
                  r_state <= LOAD;
                  r_run   <= 1'b0;
               end
            end
            default: begin
               r_state <= LOAD;
               r_run   <= 1'b0;
            end
         endcase

         r_dv <= w_fetch;
         if (w_fetch) begin
`ifdef INST_MEM_BOUNDS_CHECK_EN
            r_inst <= w_oob ? cNop : r_mem[w_idx];
`else
            r_inst <= r_mem[w_idx];
`endif
         end
      end
   end

   assign bus.oFetchInst = r_inst;
   assign bus.oFetchDv   = r_dv;
   assign bus.oInstCount = r_count;
   assign bus.oLoadFull  = r_full;
   assign bus.oRunning   = r_run;
endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: directed scenarios with literal expectations plus random traffic against a queue/array model.
module tb_inst_mem_loader;
   localparam int DEPTH = 256;
`ifdef INST_MEM_BOUNDS_CHECK_EN
   localparam bit BCHK = 1'b1;
`else
   localparam bit BCHK = 1'b0;
`endif

   logic iClk = 1'b0;
   logic iRst = 1'b1;
   logic rst8 = 1'b1;
   always #5 iClk = ~iClk;

   inst_mem_loader_if #(.cXLEN(32), .cDepth(DEPTH)) bus ();
   inst_mem_loader_if #(.cXLEN(32), .cDepth(8))     bus8 ();

   inst_mem_loader #(.cXLEN(32), .cDepth(DEPTH)) dut (.iClk(iClk), .iRst(iRst), .bus(bus));
   inst_mem_loader #(.cXLEN(32), .cDepth(8))     dut8 (.iClk(iClk), .iRst(rst8), .bus(bus8));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: memory image, word count and run flag, updated per clock from the sampled inputs.
   logic [31:0] m_mem [DEPTH];
   bit          m_known [DEPTH];
   int          m_count = 0;
   bit          m_run = 0;
   bit          m_valid = 0;
   bit          e_dv = 0, e_err = 0, e_inst_known = 0;
   logic [31:0] e_inst = '0;

   initial begin
      for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
   end

   always @(posedge iClk) begin
      int idx;
      if (iRst) begin
         m_run = 0; m_count = 0; e_dv = 0; e_err = 0;
         e_inst = '0; e_inst_known = 1; m_valid = 1;
      end else begin
         e_dv  = m_run && bus.iFetchReq;
         e_err = 0;
         if (e_dv) begin
            idx = int'(bus.iFetchAddr[9:2]);
            if (BCHK && idx >= m_count) begin
               e_inst = 32'h0000_0013; e_err = 1; e_inst_known = 1;
            end else begin
               e_inst = m_mem[idx]; e_inst_known = m_known[idx];
            end
         end
         if (!m_run) begin
            if (bus.iInstWen && m_count < DEPTH) begin
               m_mem[m_count] = bus.iInst2Write;
               m_known[m_count] = 1;
               m_count++;
            end
            if (bus.iExecute && m_count > 0) m_run = 1;
         end else if (!bus.iExecute) begin
            m_run = 0;
         end
      end
   end

   always @(negedge iClk) begin
      if (m_valid) begin
         chk("m_running", {31'b0, bus.oRunning}, {31'b0, m_run});
         chk("m_count", {23'b0, bus.oInstCount}, m_count);
         chk("m_full", {31'b0, bus.oLoadFull}, {31'b0, m_count == DEPTH});
         chk("m_dv", {31'b0, bus.oFetchDv}, {31'b0, e_dv});
         chk("m_err", {31'b0, bus.oFetchErr}, {31'b0, e_err});
         if (e_inst_known) chk("m_inst", bus.oFetchInst, e_inst);
      end
   end

   task automatic step();
      @(negedge iClk);
   endtask

   initial begin
      bit exec_r;
      bus.iInst2Write = '0; bus.iInstWen = 0; bus.iExecute = 0;
      bus.iFetchReq = 0; bus.iFetchAddr = '0;
      bus8.iInst2Write = '0; bus8.iInstWen = 0; bus8.iExecute = 0;
      bus8.iFetchReq = 0; bus8.iFetchAddr = '0;
      iRst = 1; step(); step(); iRst = 0;
      chk("rst_count", {23'b0, bus.oInstCount}, 32'd0);
      chk("rst_running", {31'b0, bus.oRunning}, 32'd0);
      chk("rst_dv", {31'b0, bus.oFetchDv}, 32'd0);
      chk("rst_inst", bus.oFetchInst, 32'd0);

      // Run request with nothing loaded is ignored; a load with execute held starts the run.
      bus.iExecute = 1; step(); step(); step();
      chk("exec_empty_running", {31'b0, bus.oRunning}, 32'd0);
      bus.iInstWen = 1; bus.iInst2Write = 32'h0010_0093; step(); bus.iInstWen = 0;
      chk("exec_wr_running", {31'b0, bus.oRunning}, 32'd1);
      chk("exec_wr_count", {23'b0, bus.oInstCount}, 32'd1);
      bus.iFetchReq = 1; bus.iFetchAddr = 32'h0; step(); bus.iFetchReq = 0;
      chk("exec_wr_dv", {31'b0, bus.oFetchDv}, 32'd1);
      chk("exec_wr_inst", bus.oFetchInst, 32'h0010_0093);
      bus.iExecute = 0; step();

      // Ten words, fetched back-to-back.
      iRst = 1; step(); iRst = 0;
      for (int i = 0; i < 10; i++) begin
         bus.iInstWen = 1; bus.iInst2Write = 32'h0010_0093 + i; step();
      end
      bus.iInstWen = 0;
      chk("load10_count", {23'b0, bus.oInstCount}, 32'd10);
      bus.iExecute = 1; step();
      chk("load10_running", {31'b0, bus.oRunning}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         bus.iFetchReq = 1; bus.iFetchAddr = i * 4; step();
         chk("b2b_dv", {31'b0, bus.oFetchDv}, 32'd1);
         chk("b2b_inst", bus.oFetchInst, 32'h0010_0093 + i);
      end
      bus.iFetchReq = 0; step();
      chk("hold_dv", {31'b0, bus.oFetchDv}, 32'd0);
      chk("hold_inst", bus.oFetchInst, 32'h0010_009C);

      // Writes ignored while running, appended after returning to LOAD.
      bus.iInstWen = 1; bus.iInst2Write = 32'hDEAD_BEAF; step(); bus.iInstWen = 0;
      chk("run_wr_count", {23'b0, bus.oInstCount}, 32'd10);
      bus.iExecute = 0; step();
      chk("back_load_running", {31'b0, bus.oRunning}, 32'd0);
      bus.iInstWen = 1; step(); bus.iInstWen = 0;
      chk("append_count", {23'b0, bus.oInstCount}, 32'd11);
      bus.iExecute = 1; step();
      bus.iFetchReq = 1; bus.iFetchAddr = 32'h28; step();
      chk("append_inst", bus.oFetchInst, 32'hDEAD_BEAF);
      // Fetch issued in the last RUN cycle still delivers.
      bus.iExecute = 0; bus.iFetchAddr = 32'h4; step();
      chk("last_run_dv", {31'b0, bus.oFetchDv}, 32'd1);
      chk("last_run_inst", bus.oFetchInst, 32'h0010_0094);
      chk("last_run_running", {31'b0, bus.oRunning}, 32'd0);
      step();
      chk("load_fetch_dv", {31'b0, bus.oFetchDv}, 32'd0);
      bus.iFetchReq = 0;

      // Four words loaded: index 4 is out of range, index 3 is not.
      iRst = 1; step(); iRst = 0;
      for (int i = 0; i < 4; i++) begin
         bus.iInstWen = 1; bus.iInst2Write = 32'h0020_0013 + i; step();
      end
      bus.iInstWen = 0; bus.iExecute = 1; step();
      bus.iFetchReq = 1; bus.iFetchAddr = 32'h10; step();
      chk("oob_dv", {31'b0, bus.oFetchDv}, 32'd1);
      chk("oob_inst", bus.oFetchInst, BCHK ? 32'h0000_0013 : 32'h0010_0097);
      chk("oob_err", {31'b0, bus.oFetchErr}, {31'b0, BCHK});
      bus.iFetchAddr = 32'h0C; step();
      chk("inb_inst", bus.oFetchInst, 32'h0020_0016);
      chk("inb_err", {31'b0, bus.oFetchErr}, 32'd0);
      bus.iFetchAddr = 32'hFFFF_FC0E; step();
      chk("addr_ignore_inst", bus.oFetchInst, 32'h0020_0016);

      // Reset in the cycle after a fetch.
      bus.iFetchAddr = 32'h0; step(); bus.iFetchReq = 0;
      chk("pre_rst_inst", bus.oFetchInst, 32'h0020_0013);
      iRst = 1; step(); iRst = 0;
      chk("rst_run_dv", {31'b0, bus.oFetchDv}, 32'd0);
      chk("rst_run_count", {23'b0, bus.oInstCount}, 32'd0);
      chk("rst_run_running", {31'b0, bus.oRunning}, 32'd0);
      bus.iExecute = 0; step();

      // Random traffic checked by the model.
      exec_r = 0;
      for (int c = 0; c < 3000; c++) begin
         iRst = ($urandom_range(299) == 0);
         bus.iInstWen = (c < 1200) ? ($urandom_range(99) < 70) : ($urandom_range(99) < 25);
         bus.iInst2Write = $urandom;
         if ($urandom_range(9) == 0) exec_r = ~exec_r;
         bus.iExecute = exec_r;
         bus.iFetchReq = $urandom_range(1);
         bus.iFetchAddr = $urandom;
         step();
      end
      iRst = 0; bus.iInstWen = 0; bus.iFetchReq = 0; bus.iExecute = 0; step();

      // Depth-8 instance: ninth word dropped, no wrap.
      step(); rst8 = 0;
      for (int i = 0; i < 9; i++) begin
         bus8.iInstWen = 1; bus8.iInst2Write = 32'hA0 + i; step();
         if (i == 6) begin
            chk("d8_count7", {28'b0, bus8.oInstCount}, 32'd7);
            chk("d8_full7", {31'b0, bus8.oLoadFull}, 32'd0);
         end
      end
      bus8.iInstWen = 0;
      chk("d8_count", {28'b0, bus8.oInstCount}, 32'd8);
      chk("d8_full", {31'b0, bus8.oLoadFull}, 32'd1);
      bus8.iExecute = 1; step();
      bus8.iFetchReq = 1; bus8.iFetchAddr = 32'h0; step();
      chk("d8_mem0", bus8.oFetchInst, 32'hA0);
      bus8.iFetchAddr = 32'h1C; step();
      chk("d8_mem7", bus8.oFetchInst, 32'hA7);
      bus8.iFetchReq = 0; step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 The block SHALL have parameter cXLEN, default 32, instruction word width in bits.
REQ-002 The block SHALL have parameter cDepth, default 256, instruction RAM depth in words; it SHALL be a power of two.
REQ-003 The block SHALL have port iClk, input, 1 bit, the only clock.
REQ-004 The block SHALL have port iRst, input, 1 bit, reset; reset is synchronous and active-high.
REQ-005 The block SHALL have port iInst2Write, input, cXLEN bits, instruction word to load.
REQ-006 The block SHALL have port iInstWen, input, 1 bit, load strobe, one word per high cycle.
REQ-007 The block SHALL have port iExecute, input, 1 bit, run request, level-sensitive.
REQ-008 The block SHALL have port iFetchReq, input, 1 bit, fetch request from the core fetch stage.
REQ-009 The block SHALL have port iFetchAddr, input, cXLEN bits, byte address of the fetch.
REQ-010 The block SHALL have port oFetchInst, output, cXLEN bits, fetched instruction.
REQ-011 The block SHALL have port oFetchDv, output, 1 bit, oFetchInst valid, one-cycle pulse.
REQ-012 The block SHALL have port oInstCount, output, log2(cDepth)+1 bits, number of words loaded.
REQ-013 The block SHALL have port oLoadFull, output, 1 bit, asserted when oInstCount equals cDepth.
REQ-014 The block SHALL have port oRunning, output, 1 bit, asserted in state RUN.
REQ-015 The block SHALL have port oFetchErr, output, 1 bit, out-of-range fetch flag; it is driven only when the bounds check is compiled in (REQ-030).

Function
REQ-016 The FSM SHALL have two states, LOAD and RUN, and SHALL enter LOAD from reset.
REQ-017 In LOAD, iInstWen=1 with oLoadFull=0 SHALL write iInst2Write to mem[wrPtr], then increment wrPtr and oInstCount, with all updates visible on the next cycle.
REQ-018 In LOAD, iInstWen=1 with oLoadFull=1 SHALL drop the word and leave the count unchanged, with no wrap.
REQ-019 LOAD -> RUN SHALL occur when iExecute=1 and either oInstCount>0 or a same-cycle write is accepted; iExecute=1 with count 0 and no write SHALL be ignored.
REQ-020 A simultaneous iInstWen and iExecute in LOAD SHALL perform the write and the transition, and the written word SHALL be fetchable.
REQ-021 RUN -> LOAD SHALL occur on the first cycle with iExecute=0; wrPtr and oInstCount SHALL be retained, so later loads append.
REQ-022 In RUN, iInstWen SHALL be ignored and the memory SHALL NOT be written.
REQ-023 In RUN, iFetchReq=1 SHALL produce oFetchDv=1 exactly one cycle later, with oFetchInst=mem[iFetchAddr[log2(cDepth)+1:2]].
REQ-024 Bits iFetchAddr[1:0] and the address bits above the index SHALL be ignored.
REQ-025 Back-to-back fetch requests SHALL give one result per cycle at full throughput.
REQ-026 iFetchReq outside RUN SHALL give oFetchDv=0.
REQ-027 oFetchInst SHALL hold its last value when oFetchDv=0.
REQ-028 A fetch issued in the last RUN cycle SHALL still deliver its result on the next cycle.

Reset
REQ-029 While iRst=1 at a clock edge, the block SHALL set state=LOAD, wrPtr=0, oInstCount=0, oLoadFull=0, oRunning=0, oFetchDv=0, oFetchErr=0, and oFetchInst=0; memory contents are not cleared. Reset mid-RUN SHALL abort any pending fetch, so no oFetchDv appears after reset.

Configuration
REQ-030 With INST_MEM_BOUNDS_CHECK_EN defined, a fetch whose word index is >= oInstCount SHALL return 32'h00000013 (NOP) with oFetchDv=1 and oFetchErr=1 for that cycle; oFetchErr SHALL otherwise be 0.
REQ-031 Without INST_MEM_BOUNDS_CHECK_EN, oFetchErr SHALL be tied to 0, and a fetch whose index is >= oInstCount SHALL return raw memory contents.

Verification
REQ-032 The bench SHALL cover: load 10 words 0x00100093+i, iExecute=1, fetch addr 0x0,0x4,...,0x24 back-to-back -> oFetchDv high for 10 consecutive cycles with matching words, each 1-cycle latency.
REQ-033 The bench SHALL cover: iExecute=1 with count 0 -> oRunning stays 0; then load 1 word with iExecute held -> oRunning=1 next cycle, fetch 0x0 returns that word.
REQ-034 The bench SHALL cover: cDepth=8, write 9 words -> oInstCount=8, oLoadFull=1, mem[0] unchanged (no wrap).
REQ-035 The bench SHALL cover: in RUN pulse iInstWen with 0xDEADBEAF -> count unchanged; drop iExecute, write it -> count+1, appended at next index.
REQ-036 The bench SHALL cover: with INST_MEM_BOUNDS_CHECK_EN and count=4, fetch 0x10 -> oFetchInst=0x00000013, oFetchErr=1; fetch 0x0C -> oFetchErr=0.
REQ-037 The bench SHALL cover: assert iRst in the cycle after iFetchReq during RUN -> no oFetchDv, oInstCount=0, oRunning=0 on the following cycle.
